counter_32_timer_ctrl: RTL and testbench

Interval-timer sequencer for the 32-bit reversible counter (up/down select `s`, synchronous `Load`/`PData`, outputs `cnt` and ripple-carry `RC`). It latches a configuration on `start`, loads the counter, watches RC for expiry, and emits ticks. It runs in one-shot or periodic mode, counting down or up. It sits between a host register/FSM and one counter instance; the counter itself is unchanged.

---
 rtl/counter_32_timer_ctrl_pkg.sv | 15 +
 rtl/counter_32_timer_ctrl.sv | 132 +++++++++++++
 tb/tb_counter_32_timer_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_32_timer_ctrl_pkg.sv
// Shared definitions for the interval-timer sequencer: FSM state encoding and
// default counter width / idle value.
package counter_32_timer_ctrl_pkg;

    localparam int TMR_WIDTH = 32;
    localparam logic [31:0] TMR_IDLE_VAL = 32'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } tmr_state_e;

endpackage

// File: rtl/counter_32_timer_ctrl.sv
// Interval-timer sequencer driving one reversible counter through its Load/PData/s pins.
// Build option TMR_PAUSE_EN adds a pause input that freezes the counter while running.
module counter_32_timer_ctrl
    import counter_32_timer_ctrl_pkg::*;
#(
    parameter int               WIDTH    = TMR_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_VAL = WIDTH'(TMR_IDLE_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
`ifdef TMR_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_periodic,
    input  logic             cfg_up,
    output logic             busy,
    output logic             done,
    output logic             tick,
    output logic [WIDTH-1:0] remain,
    output logic             ctr_s,
    output logic             ctr_load,
    output logic [WIDTH-1:0] ctr_pdata,
    input  logic [WIDTH-1:0] ctr_cnt,
    input  logic             ctr_rc
);

    tmr_state_e       state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             periodic_q, periodic_d;
    logic             up_q, up_d;

    logic             paused;
    logic             start_ok;
    logic [WIDTH-1:0] load_val;

`ifdef TMR_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // stop always dominates a simultaneous start
    assign start_ok = start & ~stop;

    // Up-counting expires at all-ones, so preload the complement to get N+1 steps
    assign load_val = up_q ? ~period_q : period_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            period_q   <= '0;
            periodic_q <= 1'b0;
            up_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            up_q       <= up_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        up_d       = up_q;
        ctr_load   = 1'b1;
        ctr_s      = 1'b0;
        ctr_pdata  = IDLE_VAL;
        tick       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d    = LOAD;
                    period_d   = cfg_period;
                    periodic_d = cfg_periodic;
                    up_d       = cfg_up;
                end
            end

            LOAD: begin
                ctr_s     = up_q;
                ctr_pdata = load_val;
                state_d   = stop ? IDLE : RUN;
            end

            RUN: begin
                ctr_s     = up_q;
                ctr_load  = 1'b0;
                ctr_pdata = load_val;
                if (stop) begin
                    state_d = IDLE;
                end else if (paused) begin
                    // Reload the current value so the counter holds; RC is not acted on
                    ctr_load  = 1'b1;
                    ctr_pdata = ctr_cnt;
                end else if (ctr_rc) begin
                    tick = 1'b1;
                    if (periodic_q) begin
                        ctr_load = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d    = LOAD;
                    period_d   = cfg_period;
                    periodic_d = cfg_periodic;
                    up_d       = cfg_up;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q == LOAD) || (state_q == RUN);
    assign done   = (state_q == DONE);
    assign remain = up_q ? ~ctr_cnt : ctr_cnt;

endmodule

// File: tb/tb_counter_32_timer_ctrl.sv
// Bench for counter_32_timer_ctrl wired to a behavioural reversible counter.
// Directed table, hand sequences for corner cases, then random stimulus vs. a phase model.
module tb_counter_32_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        pause;
    logic [31:0] cfg_period;
    logic        cfg_periodic;
    logic        cfg_up;
    logic        busy;
    logic        done;
    logic        tick;
    logic [31:0] remain;
    logic        ctr_s;
    logic        ctr_load;
    logic [31:0] ctr_pdata;
    logic [31:0] ctr_cnt = 32'd0;
    logic        ctr_rc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_32_timer_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
`ifdef TMR_PAUSE_EN
        .pause        (pause),
`endif
        .cfg_period   (cfg_period),
        .cfg_periodic (cfg_periodic),
        .cfg_up       (cfg_up),
        .busy         (busy),
        .done         (done),
        .tick         (tick),
        .remain       (remain),
        .ctr_s        (ctr_s),
        .ctr_load     (ctr_load),
        .ctr_pdata    (ctr_pdata),
        .ctr_cnt      (ctr_cnt),
        .ctr_rc       (ctr_rc)
    );

    // Reversible counter: synchronous load, else step up or down
    always @(posedge clk) begin
        if (ctr_load)   ctr_cnt <= ctr_pdata;
        else if (ctr_s) ctr_cnt <= ctr_cnt + 32'd1;
        else            ctr_cnt <= ctr_cnt - 32'd1;
    end
    assign ctr_rc = ctr_s ? (&ctr_cnt) : (ctr_cnt == 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] n, input logic per, input logic up);
        cfg_period   = n;
        cfg_periodic = per;
        cfg_up       = up;
    endtask

    // Directed per-cycle vectors
    typedef struct {
        logic        start;
        logic        stop;
        logic [31:0] n;
        logic        per;
        logic        up;
        logic        e_busy;
        logic        e_done;
        logic        e_tick;
        logic        chk_rem;
        logic [31:0] e_rem;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(input logic st, input logic sp, input logic [31:0] n,
                                input logic per, input logic up, input logic b,
                                input logic d, input logic t, input logic cr,
                                input logic [31:0] r);
        vec_t v;
        v.start = st; v.stop = sp; v.n = n; v.per = per; v.up = up;
        v.e_busy = b; v.e_done = d; v.e_tick = t; v.chk_rem = cr; v.e_rem = r;
        return v;
    endfunction

    // Behavioural model: mode 0 idle, 1 busy (k = cycles since LOAD), 2 done
    int          m_mode;
    longint      m_k;
    logic [31:0] m_n;
    logic        m_per;
    logic        m_up;
    int          m_settle;

    task automatic model_step();
        longint rem;
        logic   exp_tick;
        rem      = 0;
        exp_tick = 1'b0;
        if (m_mode == 1 && m_k >= 1)
            rem = longint'(m_n) - ((m_k - 1) % (longint'(m_n) + 1));
        if (m_mode == 1 && m_k >= 1 && rem == 0 && !stop && !pause)
            exp_tick = 1'b1;

        chk("rnd_busy", {31'd0, busy}, {31'd0, m_mode == 1});
        chk("rnd_done", {31'd0, done}, {31'd0, m_mode == 2});
        chk("rnd_tick", {31'd0, tick}, {31'd0, exp_tick});
        if (m_mode == 1 && m_k == 0)
            chk("rnd_pdata", ctr_pdata, m_up ? ~m_n : m_n);
        if (m_mode == 1 && m_k >= 1)
            chk("rnd_remain", remain, rem[31:0]);
        if (m_mode != 1 && m_settle >= 1)
            chk("rnd_frozen", ctr_cnt, 32'd0);

        case (m_mode)
            0: begin
                if (start && !stop) begin
                    m_mode = 1; m_k = 0; m_n = cfg_period; m_per = cfg_periodic; m_up = cfg_up;
                end else begin
                    m_settle++;
                end
            end
            1: begin
                if (stop) begin
                    m_mode = 0; m_settle = 0;
                end else if (m_k == 0) begin
                    m_k = 1;
                end else if (pause) begin
                    m_k = m_k;
                end else if (rem == 0 && !m_per) begin
                    m_mode = 2; m_settle = 0;
                end else begin
                    m_k++;
                end
            end
            default: begin
                if (stop) begin
                    m_mode = 0; m_settle = 0;
                end else if (start) begin
                    m_mode = 1; m_k = 0; m_n = cfg_period; m_per = cfg_periodic; m_up = cfg_up;
                end else begin
                    m_settle++;
                end
            end
        endcase
    endtask

    initial begin
        int ticks;
        int seen;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        set_cfg(32'd0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_tick", {31'd0, tick}, 32'd0);
        chk("reset_load", {31'd0, ctr_load}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("reset_cnt", ctr_cnt, 32'd0);
        next_cycle();

        // One-shot down N=5, then periodic down N=0 with stop
        vt[0]  = mk(1, 0, 32'd5,  0, 0, 0, 0, 0, 0, 32'd0);
        vt[1]  = mk(0, 0, 32'd99, 1, 1, 1, 0, 0, 0, 32'd0);
        vt[2]  = mk(0, 0, 32'd99, 1, 1, 1, 0, 0, 1, 32'd5);
        vt[3]  = mk(0, 0, 32'd99, 1, 1, 1, 0, 0, 1, 32'd4);
        vt[4]  = mk(0, 0, 32'd99, 1, 1, 1, 0, 0, 1, 32'd3);
        vt[5]  = mk(0, 0, 32'd99, 1, 1, 1, 0, 0, 1, 32'd2);
        vt[6]  = mk(0, 0, 32'd99, 1, 1, 1, 0, 0, 1, 32'd1);
        vt[7]  = mk(0, 0, 32'd99, 1, 1, 1, 0, 1, 1, 32'd0);
        vt[8]  = mk(0, 0, 32'd99, 1, 1, 0, 1, 0, 0, 32'd0);
        vt[9]  = mk(0, 0, 32'd99, 1, 1, 0, 1, 0, 1, 32'd0);
        vt[10] = mk(1, 0, 32'd0,  1, 0, 0, 1, 0, 0, 32'd0);
        vt[11] = mk(0, 0, 32'd42, 0, 1, 1, 0, 0, 0, 32'd0);
        vt[12] = mk(0, 0, 32'd42, 0, 1, 1, 0, 1, 1, 32'd0);
        vt[13] = mk(0, 0, 32'd42, 0, 1, 1, 0, 1, 1, 32'd0);
        vt[14] = mk(0, 1, 32'd42, 0, 1, 1, 0, 0, 1, 32'd0);
        vt[15] = mk(0, 0, 32'd42, 0, 1, 0, 0, 0, 0, 32'd0);
        vt[16] = mk(0, 0, 32'd42, 0, 1, 0, 0, 0, 1, 32'd0);

        for (int i = 0; i < 17; i++) begin
            start = vt[i].start;
            stop  = vt[i].stop;
            set_cfg(vt[i].n, vt[i].per, vt[i].up);
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
            chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vt[i].e_done});
            chk($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vt[i].e_tick});
            if (vt[i].chk_rem)
                chk($sformatf("vec%0d_remain", i), remain, vt[i].e_rem);
            $display("vec %0d: busy=%0b done=%0b tick=%0b remain=%h", i, busy, done, tick, remain);
            next_cycle();
        end
        start = 1'b0; stop = 1'b0;

        // Periodic up N=3
        start = 1'b1;
        set_cfg(32'd3, 1'b1, 1'b1);
        @(negedge clk);
        next_cycle();
        start = 1'b0;
        set_cfg(32'd77, 1'b0, 1'b0);
        @(negedge clk);
        chk("up3_pdata", ctr_pdata, 32'hFFFF_FFFC);
        chk("up3_busy", {31'd0, busy}, 32'd1);
        next_cycle();
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("up3_remain", remain, 32'(3 - (i % 4)));
            chk("up3_tick", {31'd0, tick}, {31'd0, (i % 4) == 3});
            if (tick) ticks++;
            next_cycle();
        end
        chk("up3_tick_count", 32'(ticks), 32'd5);
        $display("periodic up N=3: %0d ticks", ticks);
        stop = 1'b1;
        @(negedge clk);
        next_cycle();
        stop = 1'b0;
        @(negedge clk);
        chk("up3_stop_busy", {31'd0, busy}, 32'd0);
        next_cycle();

        // start while busy is ignored; start+stop together in RUN returns to IDLE
        start = 1'b1;
        set_cfg(32'd7, 1'b1, 1'b0);
        @(negedge clk);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        next_cycle();
        for (int i = 0; i < 24; i++) begin
            start = (i == 2);
            if (i == 2) set_cfg(32'd100, 1'b0, 1'b1);
            @(negedge clk);
            chk("busy_start_remain", remain, 32'(7 - (i % 8)));
            chk("busy_start_tick", {31'd0, tick}, {31'd0, (i % 8) == 7});
            next_cycle();
        end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        chk("startstop_tick", {31'd0, tick}, 32'd0);
        next_cycle();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("startstop_busy", {31'd0, busy}, 32'd0);
        chk("startstop_done", {31'd0, done}, 32'd0);
        $display("start-while-busy sequence: busy=%0b done=%0b", busy, done);
        next_cycle();

        // Reset mid-run at remain=2
        start = 1'b1;
        set_cfg(32'd5, 1'b0, 1'b0);
        @(negedge clk);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            next_cycle();
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_remain", remain, 32'd2);
        chk("rstmid_tick", {31'd0, tick}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_tick2", {31'd0, tick}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rstmid_cnt", ctr_cnt, 32'd0);
        $display("reset mid-run: cnt=%h", ctr_cnt);
        next_cycle();

`ifdef TMR_PAUSE_EN
        // Pause 4 cycles at remain=6 delays the tick by exactly 4 cycles
        start = 1'b1;
        set_cfg(32'd10, 1'b0, 1'b0);
        @(negedge clk);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        next_cycle();
        seen = 0;
        for (int c = 1; c <= 40; c++) begin
            pause = (c >= 5 && c <= 8);
            @(negedge clk);
            if (pause) begin
                chk("pause_hold", ctr_cnt, 32'd6);
                chk("pause_busy", {31'd0, busy}, 32'd1);
            end
            if (tick && seen == 0) seen = c;
            next_cycle();
            if (seen != 0) break;
        end
        pause = 1'b0;
        chk("pause_tick_cycle", 32'(seen), 32'd15);
        $display("pause: tick at RUN cycle %0d", seen);
        stop = 1'b1;
        @(negedge clk);
        next_cycle();
        stop = 1'b0;
`else
        seen = 0;
`endif

        // Random stimulus against the phase model
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        m_mode = 0; m_k = 0; m_n = 0; m_per = 0; m_up = 0; m_settle = 0;
        ticks = 0;
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            set_cfg(($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 9)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`ifdef TMR_PAUSE_EN
            pause = ($urandom_range(0, 7) == 0);
`else
            pause = 1'b0;
`endif
            @(negedge clk);
            if (tick) ticks++;
            model_step();
            next_cycle();
        end
        $display("random phase: 4000 cycles, %0d ticks", ticks);
        start = 1'b0; stop = 1'b0; pause = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
